// File: rtl/mdu_if.sv
// Operand/result bus between the E-stage pipeline and the multiply/divide unit.
interface mdu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDUOp;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output A, output B, output MDUOp, output Start,
                    input  Busy, input HI, input LO);
    modport slave  (input  A, input B, input MDUOp, input Start,
                    output Busy, output HI, output LO);
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle MIPS-style multiply/divide unit with HI/LO registers.
// Define MDU_DIV_EN to build the div/divu datapath; otherwise those opcodes are no-ops.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic  clk,
    input  logic  rst_n,
    mdu_if.slave  bus
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [31:0]     a_q,     a_d;
    logic [31:0]     b_q,     b_d;
    logic [1:0]      op_q,    op_d;   // {is_div, is_unsigned}
    logic [31:0]     hi_q,    hi_d;
    logic [31:0]     lo_q,    lo_d;

    logic signed [32:0] ma_s, mb_s;
    logic signed [63:0] prod_s;

    // Product of the latched operands; a 33rd bit selects signed vs unsigned
    always_comb begin
        ma_s   = $signed({(~op_q[0]) & a_q[31], a_q});
        mb_s   = $signed({(~op_q[0]) & b_q[31], b_q});
        prod_s = 64'(ma_s) * 64'(mb_s);
    end

`ifdef MDU_DIV_EN
    logic        a_neg_s, b_neg_s;
    logic [31:0] a_mag_s, b_mag_s, b_safe_s, uq_s, ur_s, quo_s, rem_s;

    // Sign-magnitude division: quotient truncates toward zero, remainder follows dividend
    always_comb begin
        a_neg_s  = (~op_q[0]) & a_q[31];
        b_neg_s  = (~op_q[0]) & b_q[31];
        a_mag_s  = a_neg_s ? (32'd0 - a_q) : a_q;
        b_mag_s  = b_neg_s ? (32'd0 - b_q) : b_q;
        b_safe_s = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
        uq_s     = a_mag_s / b_safe_s;
        ur_s     = a_mag_s % b_safe_s;
        quo_s    = (a_neg_s ^ b_neg_s) ? (32'd0 - uq_s) : uq_s;
        rem_s    = a_neg_s ? (32'd0 - ur_s) : ur_s;
    end
`endif

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 2'b00;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state: accept in IDLE, count down in RUN, commit result on the final edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    case (bus.MDUOp)
                        3'b000, 3'b001: begin
                            a_d     = bus.A;
                            b_d     = bus.B;
                            op_d    = bus.MDUOp[1:0];
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = S_RUN;
                        end
`ifdef MDU_DIV_EN
                        3'b010, 3'b011: begin
                            a_d     = bus.A;
                            b_d     = bus.B;
                            op_d    = bus.MDUOp[1:0];
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = S_RUN;
                        end
`endif
                        3'b100:  hi_d = bus.A;
                        3'b101:  lo_d = bus.A;
                        default: begin
                        end
                    endcase
                end else begin
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    if (op_q[1]) begin
`ifdef MDU_DIV_EN
                        // A zero divisor still burns the full latency but leaves HI/LO alone
                        if (b_q != 32'd0) begin
                            hi_d = rem_s;
                            lo_d = quo_s;
                        end else begin
                        end
`endif
                    end else begin
                        hi_d = prod_s[63:32];
                        lo_d = prod_s[31:0];
                    end
                end else begin
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.Busy = (state_q == S_RUN);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases plus randomized ops against an arithmetic model.
module tb_mdu_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic [31:0] m_hi, m_lo;

    mdu_if bus ();

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_busy(input logic [2:0] op);
        if (op == 3'b000 || op == 3'b001) return 5;
        if ((op == 3'b010 || op == 3'b011) && DIV_EN) return 10;
        return 0;
    endfunction

    // Reference: what HI/LO become once the op has finished
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'b000: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
            3'b001: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'b010: if (DIV_EN && b != 32'd0) begin
                        q = sa / sb; r = sa % sb;
                        m_lo = q[31:0]; m_hi = r[31:0];
                    end
            3'b011: if (DIV_EN && b != 32'd0) begin
                        m_lo = a / b; m_hi = a % b;
                    end
            3'b100: m_hi = a;
            3'b101: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue one op, optionally poke Start at Busy cycle 2, count Busy cycles
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit mid_en, input logic [2:0] mid_op, input logic [31:0] mid_a,
                         output int nbusy);
        @(negedge clk);
        bus.Start = 1'b1; bus.MDUOp = op; bus.A = a; bus.B = b;
        @(negedge clk);
        bus.Start = 1'b0; bus.A = $urandom; bus.B = $urandom; bus.MDUOp = 3'($urandom);
        nbusy = 0;
        while (bus.Busy && nbusy < 64) begin
            nbusy++;
            if (mid_en && nbusy == 2) begin
                bus.Start = 1'b1; bus.MDUOp = mid_op; bus.A = mid_a;
            end else begin
                bus.Start = 1'b0;
            end
            @(negedge clk);
        end
        bus.Start = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input bit mid_en, input logic [2:0] mid_op, input logic [31:0] mid_a);
        int n, e;
        e = exp_busy(op);
        issue(op, a, b, mid_en, mid_op, mid_a, n);
        model_op(op, a, b);
        checks++;
        if (n !== e) begin
            errors++;
            $display("FAIL %s busy_cycles got %0d expected %0d (op=%b a=%h b=%h)", name, n, e, op, a, b);
        end
        checks++;
        if (bus.HI !== m_hi || bus.LO !== m_lo) begin
            errors++;
            $display("FAIL %s hilo got %h_%h expected %h_%h (op=%b a=%h b=%h)",
                     name, bus.HI, bus.LO, m_hi, m_lo, op, a, b);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.Start = 1'b0; bus.A = 32'd0; bus.B = 32'd0; bus.MDUOp = 3'b000;
        repeat (2) @(negedge clk);
        m_hi = 32'd0; m_lo = 32'd0;
        checks++;
        if (bus.Busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
            errors++;
            $display("FAIL reset busy=%b hi=%h lo=%h expected 0/0/0", bus.Busy, bus.HI, bus.LO);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_mult();
        run_and_check("mult_neg", 3'b000, 32'hFFFFFFFF, 32'h00000002, 1'b0, 3'b000, 32'd0);
        checks++;
        if (bus.HI !== 32'hFFFFFFFF || bus.LO !== 32'hFFFFFFFE) begin
            errors++;
            $display("FAIL mult_const got %h_%h expected ffffffff_fffffffe", bus.HI, bus.LO);
        end
        run_and_check("multu_restart", 3'b001, 32'hFFFFFFFF, 32'h00000002, 1'b1, 3'b001, 32'h7);
        checks++;
        if (bus.HI !== 32'h00000001 || bus.LO !== 32'hFFFFFFFE) begin
            errors++;
            $display("FAIL multu_const got %h_%h expected 00000001_fffffffe", bus.HI, bus.LO);
        end
    endtask

    task automatic test_mthi_mtlo();
        int busy_seen;
        busy_seen = 0;
        @(negedge clk);
        bus.Start = 1'b1; bus.MDUOp = 3'b100; bus.A = 32'h12345678;
        @(negedge clk);
        busy_seen += int'(bus.Busy);
        bus.MDUOp = 3'b101; bus.A = 32'h9ABCDEF0;
        @(negedge clk);
        busy_seen += int'(bus.Busy);
        bus.Start = 1'b0;
        @(negedge clk);
        busy_seen += int'(bus.Busy);
        model_op(3'b100, 32'h12345678, 32'd0);
        model_op(3'b101, 32'h9ABCDEF0, 32'd0);
        checks++;
        if (busy_seen !== 0 || bus.HI !== 32'h12345678 || bus.LO !== 32'h9ABCDEF0) begin
            errors++;
            $display("FAIL mthi_mtlo busy_seen=%0d hilo=%h_%h expected 0 12345678_9abcdef0",
                     busy_seen, bus.HI, bus.LO);
        end
        run_and_check("mthi_in_run", 3'b001, 32'h00000003, 32'h00000005, 1'b1, 3'b100, 32'hDEADBEEF);
    endtask

    task automatic test_div();
        run_and_check("div_neg", 3'b010, 32'hFFFFFFF9, 32'h00000002, 1'b0, 3'b000, 32'd0);
        if (DIV_EN) begin
            checks++;
            if (bus.HI !== 32'hFFFFFFFF || bus.LO !== 32'hFFFFFFFD) begin
                errors++;
                $display("FAIL div_const got %h_%h expected ffffffff_fffffffd", bus.HI, bus.LO);
            end
        end
        run_and_check("divu_zero", 3'b011, 32'h00001234, 32'h00000000, 1'b0, 3'b000, 32'd0);
        run_and_check("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 1'b0, 3'b000, 32'd0);
        run_and_check("div_10_2", 3'b010, 32'd10, 32'd2, 1'b0, 3'b000, 32'd0);
        run_and_check("reserved", 3'b110, 32'h55555555, 32'h1, 1'b0, 3'b000, 32'd0);
        run_and_check("reserved7", 3'b111, 32'hAAAAAAAA, 32'h1, 1'b0, 3'b000, 32'd0);
    endtask

    task automatic test_reset_abort();
        int n;
        run_and_check("preload", 3'b100, 32'hCAFEF00D, 32'd0, 1'b0, 3'b000, 32'd0);
        @(negedge clk);
        bus.Start = 1'b1; bus.MDUOp = 3'b000; bus.A = 32'd3; bus.B = 32'd4;
        @(negedge clk);
        bus.Start = 1'b0;
        n = 1;
        while (n < 3) begin @(negedge clk); n++; end
        #2 rst_n = 1'b0;
        #1;
        m_hi = 32'd0; m_lo = 32'd0;
        checks++;
        if (bus.Busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
            errors++;
            $display("FAIL reset_abort busy=%b hi=%h lo=%h expected 0/0/0", bus.Busy, bus.HI, bus.LO);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_and_check("mult_after_reset", 3'b000, 32'd3, 32'd4, 1'b0, 3'b000, 32'd0);
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: a = 32'h80000000;
                default: ;
            endcase
            run_and_check("random", op, a, b, ($urandom_range(0, 3) == 0),
                          3'($urandom_range(0, 7)), $urandom);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mult();
        test_mthi_mtlo();
        test_div();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5: number of Busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10: number of Busy cycles for div/divu.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 A  input  32  operand rs, from E-stage forwarding.
REQ-006 B  input  32  operand rt, i.e. the ALU B-operand register value (RT_E) after forwarding.
REQ-007 MDUOp  input  3  operation: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 11x reserved.
REQ-008 Start  input  1  one-cycle request to perform MDUOp.
REQ-009 Busy  output  1  high while a multi-cycle operation is in progress.
REQ-010 HI  output  32  HI register.
REQ-011 LO  output  32  LO register.

Function
REQ-012 The block SHALL implement a two-state FSM, IDLE and RUN, with a cycle counter sized to hold max(MULT_CYCLES, DIV_CYCLES).
REQ-013 In IDLE, a rising edge with Start=1 and MDUOp in {000..011} SHALL do the following:
- latch A, B and the op;
- load the counter with MULT_CYCLES or DIV_CYCLES;
- enter RUN.
REQ-014 Busy SHALL equal 1 exactly while in RUN, so it is high for N consecutive cycles starting the cycle after acceptance.
REQ-015 In RUN, the counter SHALL decrement each edge. On the edge where it reaches 0, the block SHALL write HI/LO with the result and return to IDLE (Busy low in the same cycle).
REQ-016 Results SHALL depend only on the latched operands; changes on A/B/MDUOp/Start during RUN have no effect.
REQ-017 Start during RUN SHALL be ignored. The pipeline stalls on Start|Busy, so no retry logic is needed.
REQ-018 mult/multu: {HI,LO} SHALL be the 64-bit signed/unsigned product of the latched operands.
REQ-019 div/divu: LO SHALL be the quotient truncated toward zero and HI the remainder, with the remainder's sign taken from the dividend for div.
REQ-020 Divisor 0: HI and LO SHALL be left unchanged, with the full DIV_CYCLES Busy duration kept.
REQ-021 div 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-022 mthi/mtlo with Start=1 in IDLE SHALL write A into HI/LO at that edge, with no Busy. They are ignored in RUN.
REQ-023 Reserved MDUOp with Start=1 SHALL be a no-op.
REQ-024 HI/LO SHALL be registered outputs that change only on a completion edge, an mthi/mtlo edge, or reset.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- state=IDLE, Busy=0, counter=0;
- HI=0, LO=0;
- latched operands=0.
REQ-026 Reset during RUN SHALL abort the operation with no HI/LO update. The first accepted Start after reset deasserts SHALL behave as from power-up.

Configuration
REQ-027 Macro MDU_DIV_EN defined: div/divu SHALL be implemented per REQ-019..021.
REQ-028 MDU_DIV_EN undefined: no divider logic SHALL be synthesised. MDUOp 010/011 SHALL be treated as reserved (REQ-023), with Busy never asserted for them.

Verification
REQ-029 Reset, then mult A=0xFFFFFFFF B=0x00000002 Start=1 -> Busy high 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE.
REQ-030 multu A=0xFFFFFFFF B=0x00000002 -> after 5 cycles HI=0x00000001 LO=0xFFFFFFFE. A second Start at Busy cycle 2 is ignored: Busy stays high for 5 total cycles only.
REQ-031 (MDU_DIV_EN) div A=0xFFFFFFF9 (-7) B=0x00000002 -> Busy 10 cycles, then LO=0xFFFFFFFD HI=0xFFFFFFFF. divu with B=0 -> Busy 10 cycles, HI/LO unchanged.
REQ-032 mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles -> HI=0x12345678 LO=0x9ABCDEF0, Busy never high. The same mthi issued during RUN leaves HI unchanged.
REQ-033 Start mult 3*4, pull rst_n low at Busy cycle 3 -> Busy=0 HI=LO=0 immediately. After release, mult 3*4 -> LO=0x0000000C HI=0 after 5 cycles.
REQ-034 (MDU_DIV_EN undefined) div A=10 B=2 Start=1 -> Busy stays 0, HI/LO unchanged.
